// File: rtl/alu_seq_ctrl_if.sv
// Switch/button side and result side of the sequential ALU controller.
// The master drives operands and strobes; the slave returns registered results.
interface alu_seq_ctrl_if #(
    parameter int unsigned NB_DATA = 8
);
    logic [NB_DATA-1:0] i_data;
    logic [2:0]         i_valid;
    logic [NB_DATA-1:0] o_result;
    logic               o_zero;
    logic               o_carry;
    logic               o_overflow;
    logic               o_error;
    logic               o_done;

    modport master (
        output i_data, i_valid,
        input  o_result, o_zero, o_carry, o_overflow, o_error, o_done
    );

    modport slave (
        input  i_data, i_valid,
        output o_result, o_zero, o_carry, o_overflow, o_error, o_done
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Button-driven ALU: three debounced strobes load A, B and the opcode from the
// switches; each accepted load cycle refreshes the registered result and pulses o_done.
module alu_seq_ctrl #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OPERATION    = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic          i_clock,
    input logic          i_reset,
    alu_seq_ctrl_if.slave bus
);
    localparam int unsigned NB_CNT = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned MSB = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(6'b100000);
    localparam logic [NB_OPERATION-1:0] OP_SUB = NB_OPERATION'(6'b100010);
    localparam logic [NB_OPERATION-1:0] OP_AND = NB_OPERATION'(6'b100100);
    localparam logic [NB_OPERATION-1:0] OP_OR  = NB_OPERATION'(6'b100101);
    localparam logic [NB_OPERATION-1:0] OP_XOR = NB_OPERATION'(6'b100110);
    localparam logic [NB_OPERATION-1:0] OP_NOR = NB_OPERATION'(6'b100111);
    localparam logic [NB_OPERATION-1:0] OP_SRA = NB_OPERATION'(6'b000011);
    localparam logic [NB_OPERATION-1:0] OP_SRL = NB_OPERATION'(6'b000010);

    logic [2:0]              r_s1;
    logic [2:0]              r_s2;
    logic [2:0]              r_db;
    logic [NB_CNT-1:0]       r_cnt [3];
    logic [NB_DATA-1:0]      r_a;
    logic [NB_DATA-1:0]      r_b;
    logic [NB_OPERATION-1:0] r_op;
    logic                    r_load;
    logic [NB_DATA-1:0]      r_result;
    logic                    r_zero;
    logic                    r_carry;
    logic                    r_overflow;
    logic                    r_error;
    logic                    r_done;

    logic [2:0]              w_rise;
    logic [NB_OPERATION-1:0] w_op_src;
    logic [NB_DATA:0]        w_sum;
    logic [NB_DATA:0]        w_diff;
    logic                    w_shift_big;
    logic [NB_DATA-1:0]      w_res;
    logic                    w_carry;
    logic                    w_overflow;
    logic                    w_error;
    logic                    w_zero;

    // A load fires on the same edge the debounced level commits a 0->1 change
    always_comb begin
        w_rise = '0;
        for (int ch = 0; ch < 3; ch++) begin
            w_rise[ch] = r_s2[ch] & ~r_db[ch] & (r_cnt[ch] == CNT_LAST);
        end
    end

    assign w_op_src = NB_OPERATION'(bus.i_data);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_db <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_s1 <= bus.i_valid;
            r_s2 <= r_s1;
            for (int ch = 0; ch < 3; ch++) begin
                if (r_s2[ch] == r_db[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] == CNT_LAST) begin
                    r_db[ch]  <= r_s2[ch];
                    r_cnt[ch] <= '0;
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + NB_CNT'(1);
                end
            end
        end
    end

    // Operand/opcode registers; all strobes firing together share one i_data sample
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= OP_ADD;
            r_load <= 1'b0;
        end else begin
            if (w_rise[0]) r_a  <= bus.i_data;
            if (w_rise[1]) r_b  <= bus.i_data;
            if (w_rise[2]) r_op <= w_op_src;
            r_load <= |w_rise;
        end
    end

    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
    assign w_shift_big = (r_b >= SHIFT_LIMIT);

    always_comb begin
        w_res      = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_error    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res      = w_sum[NB_DATA-1:0];
                w_carry    = w_sum[NB_DATA];
                w_overflow = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_res      = w_diff[NB_DATA-1:0];
                w_carry    = w_diff[NB_DATA];
                w_overflow = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOR: w_res = ~(r_a | r_b);
            OP_SRA: w_res = w_shift_big ? {NB_DATA{r_a[MSB]}}
                                        : $unsigned($signed(r_a) >>> r_b);
            OP_SRL: w_res = w_shift_big ? '0 : (r_a >> r_b);
            default: w_error = 1'b1;
        endcase
        w_zero = ~w_error & (w_res == '0);
    end

    // Results only move on the cycle after a load, together with o_done
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= r_load;
            if (r_load) begin
                r_result   <= w_res;
                r_zero     <= w_zero;
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
                r_error    <= w_error;
            end
        end
    end

    assign bus.o_result   = r_result;
    assign bus.o_zero     = r_zero;
    assign bus.o_carry    = r_carry;
    assign bus.o_overflow = r_overflow;
    assign bus.o_error    = r_error;
    assign bus.o_done     = r_done;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a driver presses buttons and queues the expected
// result of each accepted load; a monitor checks every o_done and that outputs hold otherwise.
module tb_alu_seq_ctrl;
    localparam int unsigned NBD = 8;
    localparam int unsigned NBO = 6;
    localparam int unsigned DB  = 4;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        logic       e;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.NB_DATA(NBD)) bus ();

    alu_seq_ctrl #(
        .NB_DATA(NBD),
        .NB_OPERATION(NBO),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    exp_t       q[$];
    exp_t       last;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [5:0] m_op = 6'b100000;
    logic       end_req = 1'b0;
    logic       end_ack = 1'b0;
    logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b000011, 6'b000010};

    // Reference ALU in plain integer arithmetic
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        exp_t x;
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        x.res = 8'h00; x.c = 1'b0; x.v = 1'b0; x.e = 1'b0; x.cyc = 0;
        case (op)
            6'b100000: begin r = ia + ib; x.res = 8'(r); x.c = (r > 255);
                             x.v = (sa + sb > 127) || (sa + sb < -128); end
            6'b100010: begin r = ia - ib; x.res = 8'(r); x.c = (ia < ib);
                             x.v = (sa - sb > 127) || (sa - sb < -128); end
            6'b100100: x.res = a & b;
            6'b100101: x.res = a | b;
            6'b100110: x.res = a ^ b;
            6'b100111: x.res = ~(a | b);
            6'b000011: x.res = (ib >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> ib);
            6'b000010: x.res = (ib >= 8) ? 8'h00 : 8'(ia >> ib);
            default:   x.e = 1'b1;
        endcase
        x.z = !x.e && (x.res == 8'h00);
        return x;
    endfunction

    function automatic bit outs_differ(input exp_t e);
        return (bus.o_result !== e.res) || (bus.o_zero !== e.z) || (bus.o_carry !== e.c) ||
               (bus.o_overflow !== e.v) || (bus.o_error !== e.e);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples 1 time unit after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            last.res = 8'h00; last.z = 1'b1; last.c = 1'b0; last.v = 1'b0; last.e = 1'b0; last.cyc = 0;
            checks++;
            if (outs_differ(last) || bus.o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals got res=%02h z%0b c%0b v%0b e%0b done%0b need res=00 z1 c0 v0 e0 done0",
                         bus.o_result, bus.o_zero, bus.o_carry, bus.o_overflow, bus.o_error, bus.o_done);
            end
        end else begin
            if (q.size() > 0 && cyc > q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done got no o_done by cycle %0d need o_done at cycle %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.o_done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got o_done at cycle %0d need none", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (outs_differ(e) || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done_result got res=%02h z%0b c%0b v%0b e%0b cyc=%0d need res=%02h z%0b c%0b v%0b e%0b cyc=%0d",
                                 bus.o_result, bus.o_zero, bus.o_carry, bus.o_overflow, bus.o_error, cyc,
                                 e.res, e.z, e.c, e.v, e.e, e.cyc);
                    end
                    last = e;
                end
            end else begin
                checks++;
                if (outs_differ(last)) begin
                    errors++;
                    $display("FAIL hold got res=%02h z%0b c%0b v%0b e%0b at cycle %0d need res=%02h z%0b c%0b v%0b e%0b",
                             bus.o_result, bus.o_zero, bus.o_carry, bus.o_overflow, bus.o_error, cyc,
                             last.res, last.z, last.c, last.v, last.e);
                end
            end
        end
        if (end_req && !end_ack) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d pending loads need 0", q.size());
            end
            end_ack = 1'b1;
        end
    end

    // Hold the buttons in mask for hold cycles; a press of at least DB cycles is accepted
    task automatic press(input logic [2:0] mask, input logic [7:0] data, input int hold);
        exp_t e;
        @(negedge clk);
        bus.i_data  = data;
        bus.i_valid = mask;
        if (hold >= int'(DB)) begin
            if (mask[0]) m_a = data;
            if (mask[1]) m_b = data;
            if (mask[2]) m_op = data[5:0];
            e = model(m_a, m_b, m_op);
            e.cyc = cyc + 1 + int'(DB) + 2;
            q.push_back(e);
        end
        repeat (hold) @(negedge clk);
        bus.i_valid = 3'b000;
        repeat (DB + 4) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [7:0] d;
        bus.i_data  = 8'h00;
        bus.i_valid = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Signed-overflow add
        press(3'b001, 8'h7F, DB + 1);
        press(3'b010, 8'h01, DB + 1);
        press(3'b100, 8'h20, DB + 1);
        // Subtraction: zero then borrow
        press(3'b100, 8'h22, DB + 1);
        press(3'b001, 8'h05, DB + 1);
        press(3'b010, 8'h05, DB + 1);
        press(3'b001, 8'h03, DB + 1);
        // Shifts, including amounts beyond the width
        press(3'b001, 8'h80, DB + 1);
        press(3'b010, 8'h02, DB + 1);
        press(3'b100, 8'h03, DB + 1);
        press(3'b100, 8'h02, DB + 1);
        press(3'b010, 8'h09, DB + 1);
        press(3'b100, 8'h03, DB + 1);
        // Glitch rejection, then a simultaneous A+B load
        press(3'b001, 8'h55, 2);
        press(3'b011, 8'h11, DB + 1);
        // Debounce boundary: one short of the threshold, then exactly at it
        press(3'b001, 8'h12, DB - 1);
        press(3'b001, 8'h34, DB);
        // Invalid opcode then recovery with OR
        press(3'b100, 8'h3F, DB + 1);
        press(3'b100, 8'h25, DB + 1);
        // All three strobes together
        press(3'b111, 8'h20, DB + 2);

        // Reset during an opcode debounce; button stays held across release
        @(negedge clk);
        bus.i_data  = 8'h25;
        bus.i_valid = 3'b100;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_a = 8'h00;
        m_b = 8'h00;
        m_op = 6'b100000;
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_op = 6'b100101;
        e = model(m_a, m_b, m_op);
        e.cyc = cyc + 1 + int'(DB) + 2;
        q.push_back(e);
        repeat (DB + 3) @(negedge clk);
        bus.i_valid = 3'b000;
        repeat (DB + 4) @(negedge clk);

        // Randomized presses, biased toward valid opcodes
        for (int i = 0; i < 40; i++) begin
            logic [2:0] mask;
            int hold;
            mask = 3'($urandom_range(1, 7));
            d = 8'($urandom);
            if (mask[2] && $urandom_range(0, 9) < 8) d[5:0] = ops[$urandom_range(0, 7)];
            hold = $urandom_range(1, DB + 3);
            press(mask, d, hold);
        end

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, operand/result width (>=2).
REQ-002 SHALL have parameter NB_OPERATION, default 6, opcode width (>=6).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a strobe level change (>=1).
REQ-004 SHALL have port i_clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_data  input  NB_DATA  operand/opcode source (switches); opcode taken from i_data[NB_OPERATION-1:0], zero-extended when NB_DATA < NB_OPERATION.
REQ-007 SHALL have port i_valid  input  3  asynchronous level strobes (buttons): bit0 load A, bit1 load B, bit2 load opcode.
REQ-008 SHALL have port o_result  output  NB_DATA  registered ALU result.
REQ-009 SHALL have ports o_zero, o_carry, o_overflow, o_error  output  1 each  registered flags.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse marking a result update.

Function
REQ-011 Each i_valid bit SHALL pass a 2-flop synchronizer (s1, s2) before use.
REQ-012 Per channel debouncer: db level and counter; s2==db -> counter cleared; s2!=db and counter==DEBOUNCE_CYCLES-1 -> db<=s2, counter cleared; else counter+1.
REQ-013 Load strobe SHALL be asserted in the cycle db transitions 0->1; 1->0 transitions SHALL cause no action.
REQ-014 Pulses shorter than DEBOUNCE_CYCLES cycles in s2 SHALL be rejected with no register change and no o_done.
REQ-015 i_valid bit first sampled high at edge k, held: target register loaded from i_data at edge k+DEBOUNCE_CYCLES+1; outputs and o_done=1 at edge k+DEBOUNCE_CYCLES+2.
REQ-016 Simultaneous strobes SHALL load all targeted registers from the same i_data sample and produce a single o_done pulse.
REQ-017 o_done SHALL be high for exactly one cycle per load cycle; back-to-back load cycles give back-to-back pulses.
REQ-018 Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010; all others invalid.
REQ-019 ADD: A+B mod 2^NB_DATA; o_carry = unsigned carry-out; o_overflow = signed overflow.
REQ-020 SUB: A-B mod 2^NB_DATA; o_carry = borrow (1 iff A<B unsigned); o_overflow = signed overflow.
REQ-021 AND/OR/XOR/NOR: bitwise; o_carry=0, o_overflow=0.
REQ-022 SRA/SRL: shift A right by B as unsigned amount; B>=NB_DATA -> SRA all sign bits, SRL zero; carry/overflow 0.
REQ-023 o_zero = (o_result==0) for valid opcodes.
REQ-024 Invalid opcode: o_result=0, o_error=1, o_zero=0, o_carry=0, o_overflow=0; o_done still pulses.
REQ-025 Outputs SHALL change only on the o_done cycle; otherwise hold.

Reset
REQ-026 i_reset high SHALL immediately clear synchronizers, db levels, counters, A, B; opcode register <= ADD.
REQ-027 Reset values: o_result=0, o_zero=1, o_carry=0, o_overflow=0, o_error=0, o_done=0.
REQ-028 Reset mid-debounce SHALL discard the pending transition; a button still held at release SHALL load after the full REQ-015 latency from the first post-reset sampling edge.

Verification (NB_DATA=8, NB_OPERATION=6, DEBOUNCE_CYCLES=4)
REQ-029 A=0x7F, B=0x01, op=ADD -> o_result=0x80, o_overflow=1, o_carry=0, o_zero=0, one o_done per load, latency per REQ-015.
REQ-030 SUB A=0x05,B=0x05 -> 0x00, o_zero=1, o_carry=0; then A=0x03 -> 0xFE, o_carry=1, o_overflow=0.
REQ-031 A=0x80,B=0x02: SRA -> 0xE0, SRL -> 0x20; B=0x09: SRA -> 0xFF, SRL -> 0x00.
REQ-032 i_valid[0] high 2 cycles then low -> A unchanged, no o_done; then i_valid[0] and [1] rise together with i_data=0x11 -> A=B=0x11, single o_done.
REQ-033 op=0x3F -> o_result=0x00, o_error=1, o_zero=0; reload op=OR -> o_error=0.
REQ-034 Reset asserted with i_valid[2] held mid-count -> REQ-027 values at once; after release, opcode loads per REQ-028.
